// File: rtl/arm_pipe_pkg.sv
// arm_pipe_pkg
// Purpose: definitions shared by the ARMv4 pipeline stages.
// - REG_CODE_W / REG_PC: register code width and the program-counter code.
// - WB_SRC_ALU / WB_SRC_MEM: encodings of a write port's source select.
package arm_pipe_pkg;

  localparam int unsigned REG_CODE_W = 4;
  localparam logic [REG_CODE_W-1:0] REG_PC = 4'd15;

  localparam logic WB_SRC_ALU = 1'b0;
  localparam logic WB_SRC_MEM = 1'b1;

endpackage : arm_pipe_pkg

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf
// Purpose: generic 2-entry valid/ready skid buffer on a flat W-bit payload with flush.
// Both entries (head and skid) are exposed so a parent can search everything pending.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               drop both entries and the incoming payload
//   in_vld/in_rdy/in_data   upstream side; in_rdy is a flop (skid empty)
//   out_vld/out_rdy/out_data downstream side, driven by the head entry flops
//   skid_vld/skid_data      second entry, for lookup only
module pipe_skid_buf #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_data,
  output logic         skid_vld,
  output logic [W-1:0] skid_data
);

  logic         head_vld_q, head_vld_d;
  logic         skid_vld_q, skid_vld_d;
  logic [W-1:0] head_data_q, head_data_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         accept_s;
  logic         pop_s;

  // Handshake qualifiers; the skid being empty is what makes the stage ready.
  always_comb begin
    accept_s = in_vld & ~skid_vld_q & ~flush;
    pop_s    = head_vld_q & out_rdy;
  end

  // Next-state selection of which entry holds which payload after this edge.
  always_comb begin
    head_vld_d  = head_vld_q;
    skid_vld_d  = skid_vld_q;
    head_data_d = head_data_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      // Payload flops keep stale data; only the valid bits matter.
      head_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (skid_vld_q) begin
      // Full: nothing can be accepted, only the skid can advance.
      if (pop_s) begin
        head_vld_d  = 1'b1;
        head_data_d = skid_data_q;
        skid_vld_d  = 1'b0;
      end else begin
        head_vld_d = head_vld_q;
      end
    end else if (head_vld_q) begin
      if (accept_s) begin
        if (pop_s) begin
          head_data_d = in_data;
        end else begin
          skid_vld_d  = 1'b1;
          skid_data_d = in_data;
        end
      end else begin
        head_vld_d = head_vld_q & ~pop_s;
      end
    end else begin
      if (accept_s) begin
        head_vld_d  = 1'b1;
        head_data_d = in_data;
      end else begin
        head_vld_d = 1'b0;
      end
    end
  end

  // Entry state flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_vld_q  <= 1'b0;
      skid_vld_q  <= 1'b0;
      head_data_q <= {W{1'b0}};
      skid_data_q <= {W{1'b0}};
    end else begin
      head_vld_q  <= head_vld_d;
      skid_vld_q  <= skid_vld_d;
      head_data_q <= head_data_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign in_rdy    = ~skid_vld_q;
  assign out_vld   = head_vld_q;
  assign out_data  = head_data_q;
  assign skid_vld  = skid_vld_q;
  assign skid_data = skid_data_q;

endmodule : pipe_skid_buf

// File: rtl/wb_pipe_stage.sv
// wb_pipe_stage
// Purpose: EX->WB pipeline stage carrying NUM_WP register-file write ports per
// instruction (port 0 = Rd, port 1 = base writeback), buffered by a 2-entry skid.
// Ports:
//   i_vld/o_rdy, i_cond_pass, i_wb_op, i_wb_rd_src, i_wb_rd_vld, i_wb_rd_code, i_flush : EX side
//   o_vld/i_rdy, o_wb_op, o_wb_rd_src, o_wb_rd_vld, o_wb_rd_code, o_pc_wr            : WB side
//   i_haz_code -> o_haz_hit : combinational hazard query over every pending entry
module wb_pipe_stage
  import arm_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NUM_WP = 2,
  parameter int unsigned CODE_W = REG_CODE_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_vld,
  output logic                     o_rdy,
  input  logic                     i_cond_pass,
  input  logic [NUM_WP*DATA_W-1:0] i_wb_op,
  input  logic [NUM_WP-1:0]        i_wb_rd_src,
  input  logic [NUM_WP-1:0]        i_wb_rd_vld,
  input  logic [NUM_WP*CODE_W-1:0] i_wb_rd_code,
  input  logic                     i_flush,
  output logic                     o_vld,
  input  logic                     i_rdy,
  output logic [NUM_WP*DATA_W-1:0] o_wb_op,
  output logic [NUM_WP-1:0]        o_wb_rd_src,
  output logic [NUM_WP-1:0]        o_wb_rd_vld,
  output logic [NUM_WP*CODE_W-1:0] o_wb_rd_code,
  output logic                     o_pc_wr,
  input  logic [CODE_W-1:0]        i_haz_code,
  output logic                     o_haz_hit
);

  // Payload layout, LSB first: data | src | post-transform vld | codes.
  localparam int unsigned OP_W    = NUM_WP * DATA_W;
  localparam int unsigned CODES_W = NUM_WP * CODE_W;
  localparam int unsigned SRC_LO  = OP_W;
  localparam int unsigned VLD_LO  = SRC_LO + NUM_WP;
  localparam int unsigned CODE_LO = VLD_LO + NUM_WP;
  localparam int unsigned PAY_W   = CODE_LO + CODES_W;
  localparam logic [CODE_W-1:0] PC_CODE = CODE_W'(REG_PC);

  logic [NUM_WP-1:0]  vld_cond_s;
  logic [NUM_WP-1:0]  vld_xf_s;
  logic [PAY_W-1:0]   in_pay_s;
  logic               head_vld_s;
  logic [PAY_W-1:0]   head_pay_s;
  logic               skid_vld_s;
  logic [PAY_W-1:0]   skid_pay_s;
  logic [NUM_WP-1:0]  head_pv_s;
  logic [CODES_W-1:0] head_code_s;
  logic [NUM_WP-1:0]  skid_pv_s;
  logic [CODES_W-1:0] skid_code_s;

  // Capture transforms: a failed condition kills every write, then the lowest
  // port index keeps a shared destination. Equal codes are transitive, so
  // comparing against the pre-dedup enables gives the same result as a chain.
  always_comb begin
    vld_cond_s = i_cond_pass ? i_wb_rd_vld : {NUM_WP{1'b0}};
    vld_xf_s   = vld_cond_s;
    for (int p = 1; p < NUM_WP; p++) begin
      for (int q = 0; q < p; q++) begin
        vld_xf_s[p] = vld_xf_s[p] & ~(vld_cond_s[q] &
                      (i_wb_rd_code[q*CODE_W +: CODE_W] == i_wb_rd_code[p*CODE_W +: CODE_W]));
      end
    end
  end

  assign in_pay_s = {i_wb_rd_code, vld_xf_s, i_wb_rd_src, i_wb_op};

  pipe_skid_buf #(
    .W (PAY_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (i_flush),
    .in_vld    (i_vld),
    .in_rdy    (o_rdy),
    .in_data   (in_pay_s),
    .out_vld   (head_vld_s),
    .out_rdy   (i_rdy),
    .out_data  (head_pay_s),
    .skid_vld  (skid_vld_s),
    .skid_data (skid_pay_s)
  );

  assign head_pv_s   = head_pay_s[VLD_LO +: NUM_WP];
  assign head_code_s = head_pay_s[CODE_LO +: CODES_W];
  assign skid_pv_s   = skid_pay_s[VLD_LO +: NUM_WP];
  assign skid_code_s = skid_pay_s[CODE_LO +: CODES_W];

  assign o_vld        = head_vld_s;
  assign o_wb_op      = head_pay_s[0 +: OP_W];
  assign o_wb_rd_src  = head_pay_s[SRC_LO +: NUM_WP];
  assign o_wb_rd_code = head_code_s;
  // Stale enables of an empty head must never reach the register file.
  assign o_wb_rd_vld  = head_pv_s & {NUM_WP{head_vld_s}};

  // PC write flag: any qualified head port targeting the program counter.
  always_comb begin
    o_pc_wr = 1'b0;
    for (int p = 0; p < NUM_WP; p++) begin
      o_pc_wr = o_pc_wr | (o_wb_rd_vld[p] & (head_code_s[p*CODE_W +: CODE_W] == PC_CODE));
    end
  end

  // Hazard lookup across both pending entries, ignoring the incoming one.
  always_comb begin
    o_haz_hit = 1'b0;
    for (int p = 0; p < NUM_WP; p++) begin
      o_haz_hit = o_haz_hit
                | (head_vld_s & head_pv_s[p] & (head_code_s[p*CODE_W +: CODE_W] == i_haz_code))
                | (skid_vld_s & skid_pv_s[p] & (skid_code_s[p*CODE_W +: CODE_W] == i_haz_code));
    end
  end

endmodule : wb_pipe_stage

// File: tb/tb_wb_pipe_stage.sv
// tb_wb_pipe_stage
// Purpose: self-checking bench for wb_pipe_stage (DATA_W=32, NUM_WP=2, CODE_W=4).
// A queue of at most two pending instructions models the stage; every cycle the
// outputs are compared against it, with literal expectations for the directed cases.
module tb_wb_pipe_stage;

  localparam int DATA_W = 32;
  localparam int NUM_WP = 2;
  localparam int CODE_W = 4;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     i_vld;
  logic                     o_rdy;
  logic                     i_cond_pass;
  logic [NUM_WP*DATA_W-1:0] i_wb_op;
  logic [NUM_WP-1:0]        i_wb_rd_src;
  logic [NUM_WP-1:0]        i_wb_rd_vld;
  logic [NUM_WP*CODE_W-1:0] i_wb_rd_code;
  logic                     i_flush;
  logic                     o_vld;
  logic                     i_rdy;
  logic [NUM_WP*DATA_W-1:0] o_wb_op;
  logic [NUM_WP-1:0]        o_wb_rd_src;
  logic [NUM_WP-1:0]        o_wb_rd_vld;
  logic [NUM_WP*CODE_W-1:0] o_wb_rd_code;
  logic                     o_pc_wr;
  logic [CODE_W-1:0]        i_haz_code;
  logic                     o_haz_hit;

  int n_tot = 0;
  int n_pass = 0;

  typedef struct {
    logic [63:0] op;
    logic [1:0]  src;
    logic [1:0]  vld;
    logic [7:0]  code;
  } ent_t;

  ent_t mq[$];

  wb_pipe_stage #(.DATA_W(DATA_W), .NUM_WP(NUM_WP), .CODE_W(CODE_W)) dut (
    .clk(clk), .rst_n(rst_n), .i_vld(i_vld), .o_rdy(o_rdy), .i_cond_pass(i_cond_pass),
    .i_wb_op(i_wb_op), .i_wb_rd_src(i_wb_rd_src), .i_wb_rd_vld(i_wb_rd_vld),
    .i_wb_rd_code(i_wb_rd_code), .i_flush(i_flush), .o_vld(o_vld), .i_rdy(i_rdy),
    .o_wb_op(o_wb_op), .o_wb_rd_src(o_wb_rd_src), .o_wb_rd_vld(o_wb_rd_vld),
    .o_wb_rd_code(o_wb_rd_code), .o_pc_wr(o_pc_wr), .i_haz_code(i_haz_code),
    .o_haz_hit(o_haz_hit)
  );

  always #5 clk = ~clk;

  // What the stage must record for the instruction currently presented.
  function automatic ent_t captured();
    ent_t e;
    e.op   = i_wb_op;
    e.src  = i_wb_rd_src;
    e.code = i_wb_rd_code;
    for (int p = 0; p < 2; p++) begin
      e.vld[p] = i_cond_pass && i_wb_rd_vld[p];
      for (int q = 0; q < p; q++) begin
        if (i_cond_pass && i_wb_rd_vld[q] && i_wb_rd_code[q*4 +: 4] == i_wb_rd_code[p*4 +: 4])
          e.vld[p] = 1'b0;
      end
    end
    return e;
  endfunction

  // Model: in-order queue of up to two instructions.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mq.delete();
    else if (i_flush) mq.delete();
    else if (i_vld && mq.size() < 2) begin
      if (mq.size() > 0 && i_rdy) void'(mq.pop_front());
      mq.push_back(captured());
    end else if (mq.size() > 0 && i_rdy) void'(mq.pop_front());
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic cmp();
    ent_t h;
    logic haz_m;
    logic pc_m;
    haz_m = 1'b0;
    chk("o_rdy", 64'(o_rdy), 64'(mq.size() < 2));
    chk("o_vld", 64'(o_vld), 64'(mq.size() > 0));
    foreach (mq[k]) begin
      for (int p = 0; p < 2; p++) begin
        if (mq[k].vld[p] && mq[k].code[p*4 +: 4] == i_haz_code) haz_m = 1'b1;
      end
    end
    chk("o_haz_hit", 64'(o_haz_hit), 64'(haz_m));
    if (mq.size() > 0) begin
      h = mq[0];
      pc_m = (h.vld[0] && h.code[3:0] == 4'd15) || (h.vld[1] && h.code[7:4] == 4'd15);
      chk("o_wb_op", o_wb_op, h.op);
      chk("o_wb_rd_src", 64'(o_wb_rd_src), 64'(h.src));
      chk("o_wb_rd_code", 64'(o_wb_rd_code), 64'(h.code));
      chk("o_wb_rd_vld", 64'(o_wb_rd_vld), 64'(h.vld));
      chk("o_pc_wr", 64'(o_pc_wr), 64'(pc_m));
    end else begin
      chk("o_wb_rd_vld_idle", 64'(o_wb_rd_vld), 64'h0);
      chk("o_pc_wr_idle", 64'(o_pc_wr), 64'h0);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cmp();
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_vld"}, 64'(o_vld), 64'h0);
    chk({tag, "_rdy"}, 64'(o_rdy), 64'h1);
    chk({tag, "_rd_vld"}, 64'(o_wb_rd_vld), 64'h0);
    chk({tag, "_pc_wr"}, 64'(o_pc_wr), 64'h0);
    chk({tag, "_haz"}, 64'(o_haz_hit), 64'h0);
    chk({tag, "_op"}, o_wb_op, 64'h0);
    chk({tag, "_code"}, 64'(o_wb_rd_code), 64'h0);
    chk({tag, "_src"}, 64'(o_wb_rd_src), 64'h0);
  endtask

  task automatic set_in(input logic v, input logic cp, input logic [1:0] rv, input logic [1:0] src,
                        input logic [3:0] c0, input logic [3:0] c1,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic rdy, input logic fl);
    i_vld        = v;
    i_cond_pass  = cp;
    i_wb_rd_vld  = rv;
    i_wb_rd_src  = src;
    i_wb_rd_code = {c1, c0};
    i_wb_op      = {d1, d0};
    i_rdy        = rdy;
    i_flush      = fl;
  endtask

  function automatic logic [3:0] pick_code();
    return ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
  endfunction

  initial begin
    rst_n = 1'b0;
    i_haz_code = 4'd0;
    set_in(1'b0, 1'b1, 2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b1, 1'b0);
    #2;
    rst_chk("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Passthrough and sustained throughput.
    set_in(1'b1, 1'b1, 2'b01, 2'b00, 4'd3, 4'd0, 32'h1234, 32'h0, 1'b1, 1'b0);
    tick();
    chk("pass_vld", 64'(o_vld), 64'h1);
    chk("pass_code", 64'(o_wb_rd_code[3:0]), 64'h3);
    chk("pass_op", 64'(o_wb_op[31:0]), 64'h1234);
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, 1'b1, 2'b11, 2'b10, 4'd1, 4'd2, 32'h100 + 32'(k), 32'h200 + 32'(k), 1'b1, 1'b0);
      tick();
      chk("stream_op", 64'(o_wb_op[31:0]), 64'h100 + 64'(k));
      chk("stream_rdy", 64'(o_rdy), 64'h1);
    end
    set_in(1'b0, 1'b1, 2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    chk("drain_vld", 64'(o_vld), 64'h0);

    // Backpressure: A then B, B lands in the skid.
    set_in(1'b1, 1'b1, 2'b01, 2'b01, 4'd1, 4'd0, 32'hAAAA, 32'h0, 1'b0, 1'b0);
    tick();
    chk("bp_a_rdy", 64'(o_rdy), 64'h1);
    set_in(1'b1, 1'b1, 2'b01, 2'b00, 4'd2, 4'd0, 32'hBBBB, 32'h0, 1'b0, 1'b0);
    tick();
    chk("bp_full_rdy", 64'(o_rdy), 64'h0);
    chk("bp_head_a", 64'(o_wb_op[31:0]), 64'hAAAA);
    set_in(1'b0, 1'b1, 2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    chk("bp_hold_a", 64'(o_wb_op[31:0]), 64'hAAAA);
    i_rdy = 1'b1;
    tick();
    chk("bp_head_b", 64'(o_wb_op[31:0]), 64'hBBBB);
    chk("bp_rdy_back", 64'(o_rdy), 64'h1);
    tick();
    chk("bp_empty", 64'(o_vld), 64'h0);

    // Condition fail squashes writes but keeps the slot.
    set_in(1'b1, 1'b0, 2'b11, 2'b00, 4'd7, 4'd15, 32'h1, 32'h2, 1'b1, 1'b0);
    i_haz_code = 4'd7;
    tick();
    chk("cf_vld", 64'(o_vld), 64'h1);
    chk("cf_rd_vld", 64'(o_wb_rd_vld), 64'h0);
    chk("cf_pc_wr", 64'(o_pc_wr), 64'h0);
    chk("cf_haz", 64'(o_haz_hit), 64'h0);

    // Duplicate destination: port 0 wins.
    set_in(1'b1, 1'b1, 2'b11, 2'b01, 4'd5, 4'd5, 32'h55, 32'h66, 1'b1, 1'b0);
    i_haz_code = 4'd5;
    tick();
    chk("dup_rd_vld", 64'(o_wb_rd_vld), 64'h1);
    chk("dup_haz", 64'(o_haz_hit), 64'h1);
    set_in(1'b0, 1'b1, 2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();

    // PC write held in the skid, then reaching the head.
    i_haz_code = 4'd15;
    set_in(1'b1, 1'b1, 2'b01, 2'b00, 4'd2, 4'd0, 32'h77, 32'h0, 1'b0, 1'b0);
    tick();
    chk("pc_x_haz", 64'(o_haz_hit), 64'h0);
    set_in(1'b1, 1'b1, 2'b11, 2'b10, 4'd4, 4'd15, 32'h88, 32'h99, 1'b0, 1'b0);
    tick();
    chk("pc_skid_haz", 64'(o_haz_hit), 64'h1);
    chk("pc_skid_pcwr", 64'(o_pc_wr), 64'h0);
    chk("pc_skid_rdy", 64'(o_rdy), 64'h0);
    set_in(1'b0, 1'b1, 2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    chk("pc_head_pcwr", 64'(o_pc_wr), 64'h1);
    chk("pc_head_rd_vld", 64'(o_wb_rd_vld), 64'h3);
    tick();
    chk("pc_gone_haz", 64'(o_haz_hit), 64'h0);

    // Flush with both entries full and a new entry offered.
    i_haz_code = 4'd10;
    set_in(1'b1, 1'b1, 2'b01, 2'b00, 4'd9, 4'd0, 32'h50, 32'h0, 1'b0, 1'b0);
    tick();
    set_in(1'b1, 1'b1, 2'b01, 2'b00, 4'd10, 4'd0, 32'h51, 32'h0, 1'b0, 1'b0);
    tick();
    chk("fl_pre_haz", 64'(o_haz_hit), 64'h1);
    set_in(1'b1, 1'b1, 2'b01, 2'b00, 4'd10, 4'd0, 32'h52, 32'h0, 1'b0, 1'b1);
    tick();
    chk("fl_vld", 64'(o_vld), 64'h0);
    chk("fl_rdy", 64'(o_rdy), 64'h1);
    chk("fl_haz", 64'(o_haz_hit), 64'h0);

    // Mixed traffic against the model.
    for (int n = 0; n < 80; n++) begin
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, 2'($urandom), 2'($urandom),
             pick_code(), pick_code(), $urandom, $urandom,
             $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
      i_haz_code = pick_code();
      tick();
    end

    // Asynchronous reset in the middle of a full buffer.
    set_in(1'b1, 1'b1, 2'b01, 2'b00, 4'd15, 4'd0, 32'hC0, 32'h0, 1'b0, 1'b0);
    i_haz_code = 4'd15;
    tick();
    tick();
    chk("mid_pre_rdy", 64'(o_rdy), 64'h0);
    chk("mid_pre_haz", 64'(o_haz_hit), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    rst_chk("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    set_in(1'b0, 1'b1, 2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule : tb_wb_pipe_stage
